// File: rtl/instr_sequencer_if.sv
// Bundle of the sequencer's handshake and control signals: ROM fetch,
// ALU flags, data memory request/ready and register file strobe.
interface instr_sequencer_if #(
    parameter int PC_W = 8
);
    logic            start;
    logic            done;
    logic            error;
    logic [PC_W-1:0] instr_addr;
    logic [8:0]      instr_data;
    logic [3:0]      opcode_o;
    logic [4:0]      field_o;
    logic            alu_zero;
    logic            alu_lt;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
    logic            mem_ready;

    // Sequencer side
    modport master (
        input  start, instr_data, alu_zero, alu_lt, mem_ready,
        output done, error, instr_addr, opcode_o, field_o, reg_we, mem_re, mem_we
    );

    // Environment side (ROM, ALU, data memory, register file)
    modport slave (
        output start, instr_data, alu_zero, alu_lt, mem_ready,
        input  done, error, instr_addr, opcode_o, field_o, reg_we, mem_re, mem_we
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 8-bit core. Fetches 9-bit
// instructions into IR, decodes the 4-bit opcode and drives the register
// file / data memory strobes and the PC. All strobes come straight from
// flops so they are glitch-free.
//
// Opcode map: 0000 LB, 0001 STR, 0010 LHB, 0011 MVB, 0100 LIM, 0101 MVF,
// 0110 SFT, 0111 ADD, 1000 SUB, 1001 INC, 1010 BEQ, 1011 BNE, 1100 BLT,
// 1101 JMP, 1110 HALT, 1111 TBA. Every opcode not handled explicitly is an
// ALU/move/LIM instruction that goes through WB.
module instr_sequencer #(
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    instr_sequencer_if.master bus
);
    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [3:0] OP_LB   = 4'b0000;
    localparam logic [3:0] OP_STR  = 4'b0001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_JMP  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1110;
    localparam logic [3:0] OP_TBA  = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALTED
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [8:0]        ir;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              done_r;
    logic              error_r;
    logic              reg_we_r;
    logic              mem_re_r;
    logic              mem_we_r;

    logic [3:0]        opcode;
    logic signed [4:0] off_s;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_off;
    logic              take_branch;

    assign opcode = ir[8:5];
    assign off_s  = ir[4:0];
    // Both wrap modulo 2^PC_W; the offset is sign-extended to PC width first.
    assign pc_inc = pc + PC_W'(1);
    assign pc_off = pc + PC_W'(off_s);

    assign bus.instr_addr = pc;
    assign bus.opcode_o   = ir[8:5];
    assign bus.field_o    = ir[4:0];
    assign bus.done       = done_r;
    assign bus.error      = error_r;
    assign bus.reg_we     = reg_we_r;
    assign bus.mem_re     = mem_re_r;
    assign bus.mem_we     = mem_we_r;

    // Branch decision from the ALU flags presented during EXEC; JMP always taken.
    always_comb begin
        take_branch = 1'b0;
        case (opcode)
            OP_BEQ:  take_branch = bus.alu_zero;
            OP_BNE:  take_branch = !bus.alu_zero;
            OP_BLT:  take_branch = bus.alu_lt;
            OP_JMP:  take_branch = 1'b1;
            default: take_branch = 1'b0;
        endcase
    end

    // Sequencer FSM: state, PC, IR, memory timeout and registered strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= '0;
            tmo_cnt  <= '0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
            reg_we_r <= 1'b0;
            mem_re_r <= 1'b0;
            mem_we_r <= 1'b0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (bus.start) begin
                        pc      <= '0;
                        done_r  <= 1'b0;
                        error_r <= 1'b0;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    ir    <= bus.instr_data;
                    state <= DECODE;
                end
                DECODE: begin
                    case (opcode)
                        OP_HALT: begin
                            done_r <= 1'b1;
                            state  <= HALTED;
                        end
                        OP_TBA: begin
                            pc    <= pc_inc;
                            state <= FETCH;
                        end
                        default: state <= EXEC;
                    endcase
                end
                EXEC: begin
                    case (opcode)
                        OP_BEQ, OP_BNE, OP_BLT, OP_JMP: begin
                            pc    <= take_branch ? pc_off : pc_inc;
                            state <= FETCH;
                        end
                        OP_LB: begin
                            mem_re_r <= 1'b1;
                            tmo_cnt  <= '0;
                            state    <= MEM;
                        end
                        OP_STR: begin
                            mem_we_r <= 1'b1;
                            tmo_cnt  <= '0;
                            state    <= MEM;
                        end
                        default: begin
                            reg_we_r <= 1'b1;
                            state    <= WB;
                        end
                    endcase
                end
                MEM: begin
                    if (bus.mem_ready) begin
                        mem_re_r <= 1'b0;
                        mem_we_r <= 1'b0;
                        tmo_cnt  <= '0;
                        if (opcode == OP_LB) begin
                            reg_we_r <= 1'b1;
                            state    <= WB;
                        end else begin
                            pc    <= pc_inc;
                            state <= FETCH;
                        end
                    end else if (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1)) begin
                        // This is the MEM_TIMEOUT-th cycle without ready: abort.
                        mem_re_r <= 1'b0;
                        mem_we_r <= 1'b0;
                        error_r  <= 1'b1;
                        done_r   <= 1'b1;
                        state    <= HALTED;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                WB: begin
                    reg_we_r <= 1'b0;
                    pc       <= pc_inc;
                    state    <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: small programs loaded into a ROM
// model, expected values queued on a scoreboard and compared when the
// corresponding output appears.
module tb_instr_sequencer;
    localparam int PC_W = 8;

    localparam logic [3:0] OP_LB   = 4'b0000;
    localparam logic [3:0] OP_STR  = 4'b0001;
    localparam logic [3:0] OP_LIM  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_JMP  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1110;
    localparam logic [3:0] OP_TBA  = 4'b1111;
    localparam logic [8:0] HALT_INS = {OP_HALT, 5'b00000};

    logic clk = 1'b0;
    logic reset_n;
    logic [8:0] rom [0:255];

    instr_sequencer_if #(.PC_W(PC_W)) bus ();

    instr_sequencer #(.PC_W(PC_W), .MEM_TIMEOUT(15)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    assign bus.instr_data = rom[bus.instr_addr];

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   rw_cnt, re_cnt, we_cnt;
    bit   excl_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_q.push_back('{tag, val});
    endtask

    task automatic sb_pop_chk(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $error("FAIL sb_underflow: observed %0d with no expected entry", obs);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic rom_clear();
        for (int a = 0; a < 256; a++) rom[a] = HALT_INS;
    endtask

    task automatic clr_counts();
        rw_cnt = 0; re_cnt = 0; we_cnt = 0; excl_bad = 1'b0;
    endtask

    task automatic observe();
        if (bus.reg_we) rw_cnt++;
        if (bus.mem_re) re_cnt++;
        if (bus.mem_we) we_cnt++;
        if (int'(bus.reg_we) + int'(bus.mem_re) + int'(bus.mem_we) > 1) excl_bad = 1'b1;
    endtask

    // Called on a falling edge; returns on the falling edge of the FETCH cycle.
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_done"},   bus.done,   1'b0);
        chk1({tag, "_error"},  bus.error,  1'b0);
        chk1({tag, "_reg_we"}, bus.reg_we, 1'b0);
        chk1({tag, "_mem_re"}, bus.mem_re, 1'b0);
        chk1({tag, "_mem_we"}, bus.mem_we, 1'b0);
        chk({tag, "_opcode"},  32'(bus.opcode_o),   0);
        chk({tag, "_field"},   32'(bus.field_o),    0);
        chk({tag, "_addr"},    32'(bus.instr_addr), 0);
    endtask

    task automatic run_branch(input string tag, input logic [3:0] op,
                              input logic z, input logic lt, input int exp_addr);
        rom_clear();
        rom[0] = {OP_JMP, 5'b00100};
        rom[4] = {op, 5'b11110};
        bus.alu_zero = z;
        bus.alu_lt   = lt;
        clr_counts();
        sb_push({tag, "_next_addr"}, exp_addr);
        pulse_start();
        for (int i = 1; i <= 8; i++) begin
            observe();
            if (i == 4) chk({tag, "_at_pc4"}, 32'(bus.instr_addr), 4);
            if (i == 7) sb_pop_chk(32'(bus.instr_addr));
            @(negedge clk);
        end
        chk1({tag, "_halted"}, bus.done, 1'b1);
        chk({tag, "_no_reg_we"}, rw_cnt, 0);
        bus.alu_zero = 1'b0;
        bus.alu_lt   = 1'b0;
    endtask

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int we_at;
        int re_seen;

        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.alu_zero  = 1'b0;
        bus.alu_lt    = 1'b0;
        bus.mem_ready = 1'b0;
        rom_clear();
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk1("idle_no_done", bus.done, 1'b0);
        chk("idle_addr", 32'(bus.instr_addr), 0);

        // ADD then HALT
        rom[0] = {OP_ADD, 5'b00011};
        rom[1] = HALT_INS;
        clr_counts();
        we_at = 0;
        sb_push("add_wb_opcode", int'(OP_ADD));
        pulse_start();
        for (int i = 1; i <= 8; i++) begin
            observe();
            if (bus.reg_we) begin
                we_at = i;
                sb_pop_chk(32'(bus.opcode_o));
            end
            if (i == 6) chk1("add_done_in_decode", bus.done, 1'b0);
            if (i == 7) chk1("add_done_after_halt", bus.done, 1'b1);
            @(negedge clk);
        end
        chk("add_reg_we_cycles", rw_cnt, 1);
        chk("add_reg_we_at", we_at, 4);
        chk("add_halt_pc", 32'(bus.instr_addr), 1);
        chk1("add_halt_error", bus.error, 1'b0);
        chk1("add_excl", excl_bad, 1'b0);

        // LIM with immediate 101
        rom_clear();
        rom[0] = {OP_LIM, 5'b00101};
        clr_counts();
        sb_push("lim_wb_imm", 5);
        pulse_start();
        for (int i = 1; i <= 8; i++) begin
            observe();
            if (i >= 2 && i <= 4) begin
                chk($sformatf("lim_opcode_c%0d", i), 32'(bus.opcode_o), 32'(OP_LIM));
                chk($sformatf("lim_imm_c%0d", i), 32'(bus.field_o[2:0]), 5);
            end
            if (bus.reg_we) sb_pop_chk(32'(bus.field_o[2:0]));
            if (i == 5) chk("lim_next_addr", 32'(bus.instr_addr), 1);
            @(negedge clk);
        end
        chk("lim_reg_we_cycles", rw_cnt, 1);

        // LB with ready on the 4th MEM cycle, then STR with immediate ready
        rom_clear();
        rom[0] = {OP_LB, 5'b00000};
        rom[1] = {OP_STR, 5'b00000};
        clr_counts();
        we_at   = 0;
        re_seen = 0;
        sb_push("lb_wb_opcode", int'(OP_LB));
        pulse_start();
        for (int i = 1; i <= 16; i++) begin
            observe();
            if (bus.reg_we) begin
                we_at = i;
                sb_pop_chk(32'(bus.opcode_o));
            end
            bus.start = (i == 5);
            if (bus.mem_re) begin
                re_seen++;
                bus.mem_ready = (re_seen == 4);
            end else begin
                bus.mem_ready = bus.mem_we;
            end
            @(negedge clk);
        end
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
        chk("lb_mem_re_cycles", re_cnt, 4);
        chk("lb_reg_we_at", we_at, 8);
        chk("lbstr_reg_we_cycles", rw_cnt, 1);
        chk("str_mem_we_cycles", we_cnt, 1);
        chk1("lbstr_done", bus.done, 1'b1);
        chk("lbstr_halt_pc", 32'(bus.instr_addr), 2);
        chk1("lbstr_excl", excl_bad, 1'b0);

        // Branches at PC 4 with offset -2
        run_branch("beq_z1", OP_BEQ, 1'b1, 1'b0, 2);
        run_branch("bne_z1", OP_BNE, 1'b1, 1'b0, 5);
        run_branch("blt_lt1", OP_BLT, 1'b0, 1'b1, 2);
        run_branch("beq_z0", OP_BEQ, 1'b0, 1'b0, 5);
        run_branch("bne_z0", OP_BNE, 1'b0, 1'b0, 2);
        run_branch("blt_lt0", OP_BLT, 1'b1, 1'b0, 5);

        // STR with mem_ready never arriving
        rom_clear();
        rom[0] = {OP_STR, 5'b00000};
        bus.mem_ready = 1'b0;
        clr_counts();
        pulse_start();
        for (int i = 1; i <= 18; i++) begin
            observe();
            if (i == 18) chk1("tmo_not_yet_done", bus.done, 1'b0);
            @(negedge clk);
        end
        chk("tmo_mem_we_cycles", we_cnt, 15);
        chk1("tmo_done", bus.done, 1'b1);
        chk1("tmo_error", bus.error, 1'b1);
        chk1("tmo_mem_we_dropped", bus.mem_we, 1'b0);
        rom[0] = HALT_INS;
        pulse_start();
        chk("restart_addr", 32'(bus.instr_addr), 0);
        chk1("restart_error_clr", bus.error, 1'b0);
        chk1("restart_done_clr", bus.done, 1'b0);
        repeat (2) @(negedge clk);
        chk1("restart_halted", bus.done, 1'b1);
        chk1("restart_halt_no_error", bus.error, 1'b0);

        // Asynchronous reset while waiting in MEM
        rom_clear();
        rom[0] = {OP_TBA, 5'b00000};
        rom[1] = {OP_LB, 5'b10101};
        pulse_start();
        repeat (6) @(negedge clk);
        chk1("mid_mem_re_before_rst", bus.mem_re, 1'b1);
        chk("mid_mem_addr_before_rst", 32'(bus.instr_addr), 1);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk1("post_rst_idle_done", bus.done, 1'b0);
        chk1("post_rst_idle_mem_re", bus.mem_re, 1'b0);
        chk("post_rst_idle_addr", 32'(bus.instr_addr), 0);
        rom[0] = HALT_INS;
        pulse_start();
        repeat (2) @(negedge clk);
        chk1("post_rst_resume_halted", bus.done, 1'b1);

        // JMP -1 at PC 0 wraps to 255; TBA at 255 wraps back to 0
        rom_clear();
        rom[0]   = {OP_JMP, 5'b11111};
        rom[255] = {OP_TBA, 5'b00000};
        sb_push("jmp_wrap_addr", 255);
        sb_push("inc_wrap_addr", 0);
        pulse_start();
        for (int i = 1; i <= 6; i++) begin
            if (i == 4 || i == 6) sb_pop_chk(32'(bus.instr_addr));
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1 chk_reset_vals("final_rst");
        @(negedge clk);
        reset_n = 1'b1;

        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control sequencer for the 8-bit core: fetches 9-bit instructions from instruction ROM and latches them in an instruction register (IR).
- Decodes the 4-bit opcode and drives the control strobes: register write enable, memory read/write, PC update.
- Drives the opcode and immediate field to the writeback select mux and the ALU, holding them stable through writeback.
- Sits between instruction ROM, ALU flags, data memory handshake and the register file.

Parameters:
- PC_W, 8, program counter / instruction address width; PC wraps modulo 2^PC_W.
- MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_ready before forced abort to HALTED.

Ports:
- clk  in  1  clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; starts execution from PC 0 (honoured only in IDLE or HALTED).
- done  out  1  high while in HALTED.
- error  out  1  high in HALTED if entry was via memory timeout.
- instr_addr  out  PC_W  ROM address (equals current PC).
- instr_data  in  9  ROM data, valid one cycle after instr_addr.
- opcode_o  out  4  IR[8:5]; held stable from DECODE through WB.
- field_o  out  5  IR[4:0]; LIM immediate is field_o[2:0].
- alu_zero  in  1  ALU result == 0, valid in EXEC.
- alu_lt  in  1  ALU signed less-than, valid in EXEC.
- reg_we  out  1  register file write strobe.
- mem_re  out  1  data memory read request.
- mem_we  out  1  data memory write request.
- mem_ready  in  1  data memory completion for the current request.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED.
- Reset (async, any state, including mid-MEM): state IDLE; PC=0; IR=0; timeout counter=0.
- Reset values of outputs: done=0, error=0, reg_we=0, mem_re=0, mem_we=0, opcode_o=0, field_o=0, instr_addr=0.
- IDLE/HALTED with start=1: PC<=0, done<=0, error<=0, next FETCH. start in any other state is ignored.
- FETCH, 1 cycle: instr_addr=PC; IR<=instr_data at the end of the cycle; next DECODE.
- DECODE, 1 cycle:
  - HALT (1110): next HALTED.
  - TBA (1111): NOP; PC<=PC+1; next FETCH.
  - All other opcodes: next EXEC.
- EXEC, 1 cycle; the branch decision samples alu_zero/alu_lt in this cycle. off = sign-extended field_o (range -16..+15).
  - BNE: taken iff !alu_zero.
  - BEQ: taken iff alu_zero.
  - BLT: taken iff alu_lt.
  - Branch taken: PC<=PC+off. Not taken: PC<=PC+1. Next FETCH.
  - JMP: PC<=PC+off; next FETCH.
  - LB, STR: next MEM.
  - ADD, SUB, SFT, INC, LHB, MVB, MVF, LIM: next WB.
- MEM:
  - mem_re=1 for LB, mem_we=1 for STR, held every cycle until mem_ready=1.
  - On mem_ready: LB goes to WB; STR does PC<=PC+1 and goes to FETCH.
  - mem_ready=1 in the first MEM cycle gives a 1-cycle MEM.
  - Timeout counter increments each MEM cycle without ready. If it reaches MEM_TIMEOUT: error<=1, next HALTED, strobes dropped.
- WB, 1 cycle: reg_we=1; PC<=PC+1; next FETCH.
- HALTED: done=1; all strobes 0; PC frozen.
- Cycles per instruction:
  - ALU/move/LIM: 4.
  - Branch/JMP: 3.
  - TBA: 2.
  - LB: 4 + MEM wait cycles.
  - STR: 3 + MEM wait cycles.
- Strobe exclusivity: at most one of reg_we/mem_re/mem_we is high in any cycle. All strobes are decoded from the registered state (glitch-free).
- PC arithmetic is modulo 2^PC_W. PC=2^PC_W-1 with increment wraps to 0; a negative offset below 0 wraps high.

Test Plan:
- Reset, start, ROM[0]=ADD, ROM[1]=HALT:
  - reg_we high exactly 1 cycle, 4 cycles after FETCH entry, with opcode_o=0111.
  - done=1 after the HALT DECODE; PC=1.
- LIM with field=5'b00101:
  - opcode_o=0100 and field_o[2:0]=101 are stable through WB.
  - reg_we pulses once; next instr_addr=PC+1.
- LB with mem_ready delayed 3 cycles:
  - mem_re high for 4 cycles, then reg_we for 1 cycle.
  - STR with mem_ready same cycle: mem_we for 1 cycle, reg_we never asserted.
- Branches at PC=4 with field=5'b11110 (-2):
  - BEQ with alu_zero=1: next instr_addr=2.
  - BNE with alu_zero=1: next instr_addr=5.
  - BLT with alu_lt=1: next instr_addr=2.
  - JMP at PC=0 with off=-1: instr_addr wraps to 255.
- mem_ready held low on STR: after 15 MEM cycles, done=1, error=1, mem_we=0. start then restarts from instr_addr=0 with error=0.
- reset_n asserted mid-MEM: all outputs return to reset values immediately (asynchronously); state IDLE; start is needed to resume.
